sssp_iter_sched: RTL and testbench
==================================

Name: sssp_iter_sched

Overview:
Iteration scheduler for the SSSP edge-centric engine. It sequences scatter and gather phases over PAR_NUM graph partitions.
- Scatter: issues burst read requests that stream each partition's 64-bit edge records into the pipeline.
- Gather: hands each partition to the update/apply logic.
- Repeats iterations until no vertex distance improves or the iteration cap is reached.
- Sits between the host start/config interface, the edge-memory read port and the processing pipe.

Parameters:
PAR_NUM, 32, number of partitions
PAR_NUM_W, 5, partition index width
ADDR_W, 32, byte address width
LEN_W, 24, partition edge-count width (64-bit words)
BURST, 8, max words per read request
BURST_W, 4, width of the beat-count field
ITER_W, 16, iteration counter width
MAX_ITER, 64, iteration cap

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  level; a rising edge while idle launches a run
cfg_we  in  1  config table write strobe
cfg_par  in  PAR_NUM_W  partition index to write
cfg_base  in  ADDR_W  partition edge-list byte base address
cfg_len  in  LEN_W  partition edge count, in 64-bit words
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  read request accepted
rd_req_addr  out  ADDR_W  request byte address
rd_req_beats  out  BURST_W  words in request (1..BURST)
rdata_valid  in  1  one edge word returned (the RDataV0 strobe)
ga_start  out  1  one-cycle pulse: gather partition ga_par
ga_par  out  PAR_NUM_W  partition under scatter/gather
ga_done  in  1  gather of ga_par finished
upd_any  in  1  pulse: some vertex distance improved
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
converged  out  1  last run ended with no updates
iter_cnt  out  ITER_W  iterations completed in the current/last run
err_overrun  out  1  sticky: unexpected rdata_valid

Behaviour:
- Reset (rst=0 at a clk edge): FSM to IDLE; all outputs 0; config table cleared to base=0, len=0; all counters and flags cleared. Reset mid-run aborts immediately. In-flight rdata_valid after reset counts as an overrun only after reset release.
- Config writes are accepted in any state but take effect only for partitions not yet visited in the current phase. Writes are intended for IDLE.
- The start edge detector registers start; the rise is detected only in IDLE. A rise while busy is ignored.
- FSM states: IDLE, SC_ISSUE, SC_DRAIN, GA_ISSUE, GA_WAIT, CHECK, FIN.
- IDLE -> SC_ISSUE on start rise; p=0; iter_cnt=0; upd_seen=0; busy=1 from the next cycle.
- SC_ISSUE: if len[p]==0, spend one cycle and advance p.
  - Otherwise drive rd_req_valid with addr = base[p] + (off<<3), modulo 2^ADDR_W, and beats = min(BURST, len[p]-off).
  - On valid&&ready: off += beats. When off reaches len[p], go to SC_DRAIN.
  - Valid and payload hold stable until ready.
- SC_DRAIN: wait until returned beats == len[p]. Returned beats are counted from SC_ISSUE entry, and beats may arrive during SC_ISSUE. Then p++ and off=0.
  - After p==PAR_NUM-1 completes: p=0, go to GA_ISSUE.
- Beat count rule: rdata_valid outside SC_ISSUE/SC_DRAIN, or beyond len[p], sets err_overrun and is otherwise ignored.
- GA_ISSUE: one-cycle ga_start with ga_par=p -> GA_WAIT. Every partition is gathered, including len==0 ones.
- GA_WAIT: on ga_done, p++. After PAR_NUM-1 completes, go to CHECK; otherwise return to GA_ISSUE. A ga_done in GA_ISSUE is ignored.
- upd_seen: set by upd_any in any state from SC_ISSUE through CHECK inclusive. In CHECK, use upd_seen|upd_any.
- CHECK: iter_cnt++.
  - If updated and iter_cnt+1 < MAX_ITER: clear upd_seen and go to SC_ISSUE with p=0.
  - Else go to FIN. converged = !updated.
- FIN: done=1 for one cycle; busy=0 next cycle; -> IDLE. iter_cnt and converged hold until the next start.
- ga_par equals p in all non-IDLE states; 0 in IDLE.

Optional Feature:
SSSP_SCHED_PERF_CNT_EN:
- Defined: adds 32-bit outputs perf_sc_cycles, perf_ga_cycles and perf_stall_cycles.
  - perf_sc_cycles counts cycles in SC_*.
  - perf_ga_cycles counts cycles in GA_*.
  - perf_stall_cycles counts rd_req_valid && !rd_req_ready.
  - All three clear on start rise and reset, and saturate at all-ones.
- Undefined: no ports, no logic.

Decomposition:
- Package sssp_sched_pkg holds the FSM state enum, the byte-per-edge shift constant (3) and the min-beats helper function.
- One natural sub-module: sssp_par_cfg_tab, the PAR_NUM-entry base/len table with synchronous clear and one write port plus one combinational read port indexed by p.

Test Plan:
- Config p0 base=0x1000 len=20, others len 0; upd_any never -> requests (0x1000,8), (0x1040,8), (0x1080,4); 20 beats; 32 ga_start pulses; done, converged=1, iter_cnt=1.
- Same config, upd_any pulsed once during the gather of iterations 1 and 2 -> 3 iterations, converged=1, iter_cnt=3.
- upd_any every iteration, MAX_ITER=4 -> stops with iter_cnt=4, converged=0, done pulse exactly once.
- Random rd_req_ready backpressure (50%) -> addr/beats stable while valid&&!ready; no request lost or duplicated.
- Extra rdata_valid in IDLE -> err_overrun=1 sticky until reset; start asserted while busy -> no restart.
- rst=0 during SC_DRAIN -> next cycle all outputs 0, config lens 0; a fresh start with an empty table completes in one iteration.

Source files
------------

// File: rtl/sssp_sched_pkg.sv
// Shared types, widths and helpers for the SSSP iteration scheduler.
package sssp_sched_pkg;

  localparam int PAR_NUM      = 32;
  localparam int PAR_NUM_W    = 5;
  localparam int ADDR_W       = 32;
  localparam int LEN_W        = 24;
  localparam int BURST        = 8;
  localparam int BURST_W      = 4;
  localparam int ITER_W       = 16;
  localparam int MAX_ITER_DEF = 64;
  localparam int EDGE_SHIFT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SC_ISSUE = 3'd1,
    ST_SC_DRAIN = 3'd2,
    ST_GA_ISSUE = 3'd3,
    ST_GA_WAIT  = 3'd4,
    ST_CHECK    = 3'd5,
    ST_FIN      = 3'd6
  } sched_state_e;

  // Words in the next request: whatever is left of the partition, capped at one burst.
  function automatic logic [BURST_W-1:0] min_beats(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] off);
    logic [LEN_W-1:0] rem_s;
    rem_s = len - off;
    if (rem_s > LEN_W'(BURST)) begin
      min_beats = BURST_W'(BURST);
    end else begin
      min_beats = rem_s[BURST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sssp_iter_sched_if.sv
// Edge-memory read channel and gather/apply handshake of the iteration scheduler.
interface sssp_iter_sched_if;
  import sssp_sched_pkg::*;

  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [ADDR_W-1:0]    rd_req_addr;
  logic [BURST_W-1:0]   rd_req_beats;
  logic                 rdata_valid;
  logic                 ga_start;
  logic [PAR_NUM_W-1:0] ga_par;
  logic                 ga_done;
  logic                 upd_any;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_beats, ga_start, ga_par,
    input  rd_req_ready, rdata_valid, ga_done, upd_any
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_beats, ga_start, ga_par,
    output rd_req_ready, rdata_valid, ga_done, upd_any
  );
endinterface

// File: rtl/sssp_par_cfg_tab.sv
// Per-partition edge-list base/length table: one write port, one combinational read port.
module sssp_par_cfg_tab
  import sssp_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PAR_NUM_W-1:0] wr_par,
  input  logic [ADDR_W-1:0]    wr_base,
  input  logic [LEN_W-1:0]     wr_len,
  input  logic [PAR_NUM_W-1:0] rd_par,
  output logic [ADDR_W-1:0]    rd_base,
  output logic [LEN_W-1:0]     rd_len
);

  logic [ADDR_W-1:0] base_r [PAR_NUM];
  logic [LEN_W-1:0]  len_r  [PAR_NUM];

  // Table storage; reset empties every partition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PAR_NUM; i++) begin
        base_r[i] <= ADDR_W'(0);
        len_r[i]  <= LEN_W'(0);
      end
    end else if (we) begin
      base_r[wr_par] <= wr_base;
      len_r[wr_par]  <= wr_len;
    end
  end

  assign rd_base = base_r[rd_par];
  assign rd_len  = len_r[rd_par];

endmodule

// File: rtl/sssp_iter_sched.sv
// Scatter/gather iteration scheduler for the SSSP edge-centric engine.
// Optional performance counters are built when SSSP_SCHED_PERF_CNT_EN is defined.
module sssp_iter_sched
  import sssp_sched_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_we,
  input  logic [PAR_NUM_W-1:0] cfg_par,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [LEN_W-1:0]     cfg_len,
  sssp_iter_sched_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [ITER_W-1:0]    iter_cnt,
  output logic                 err_overrun
`ifdef SSSP_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          perf_sc_cycles,
  output logic [31:0]          perf_ga_cycles,
  output logic [31:0]          perf_stall_cycles
`endif
);

  sched_state_e state_r, state_nxt_s;

  logic [PAR_NUM_W-1:0] p_r;
  logic [LEN_W-1:0]     off_r, ret_r;
  logic [ITER_W-1:0]    iter_r;
  logic                 start_q_r, upd_seen_r, converged_r, err_r;

  logic [ADDR_W-1:0]    base_s;
  logic [LEN_W-1:0]     len_s;
  logic [BURST_W-1:0]   beats_s;
  logic [ITER_W:0]      iter_inc_s;
  logic start_rise_s, req_fire_s, issue_last_s, in_sc_s, beat_ok_s;
  logic updated_s, cont_s, p_last_s, sc_adv_s, ga_adv_s, req_valid_s;

  sssp_par_cfg_tab u_cfg_tab (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_par  (cfg_par),
    .wr_base (cfg_base),
    .wr_len  (cfg_len),
    .rd_par  (p_r),
    .rd_base (base_s),
    .rd_len  (len_s)
  );

  assign start_rise_s = start & ~start_q_r & (state_r == ST_IDLE);
  assign p_last_s     = (p_r == PAR_NUM_W'(PAR_NUM - 1));
  assign beats_s      = min_beats(len_s, off_r);
  assign req_valid_s  = (state_r == ST_SC_ISSUE) && (len_s != LEN_W'(0));
  assign req_fire_s   = req_valid_s & bus.rd_req_ready;
  assign issue_last_s = req_fire_s && ((off_r + LEN_W'(beats_s)) == len_s);
  assign in_sc_s      = (state_r == ST_SC_ISSUE) || (state_r == ST_SC_DRAIN);
  // Beats may land while requests are still being issued; anything past len is an overrun.
  assign beat_ok_s    = bus.rdata_valid & in_sc_s & (ret_r < len_s);
  assign updated_s    = upd_seen_r | bus.upd_any;
  assign iter_inc_s   = {1'b0, iter_r} + (ITER_W+1)'(1'b1);
  assign cont_s       = updated_s && (iter_inc_s < (ITER_W+1)'(MAX_ITER));

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign bus.rd_req_valid = req_valid_s;
  assign bus.rd_req_addr  = req_valid_s ? (base_s + (ADDR_W'(off_r) << EDGE_SHIFT)) : ADDR_W'(0);
  assign bus.rd_req_beats = req_valid_s ? beats_s : BURST_W'(0);
  assign bus.ga_start     = (state_r == ST_GA_ISSUE);
  assign bus.ga_par       = (state_r == ST_IDLE) ? PAR_NUM_W'(0) : p_r;
  assign busy             = (state_r != ST_IDLE);
  assign done             = (state_r == ST_FIN);
  assign converged        = converged_r;
  assign iter_cnt         = iter_r;
  assign err_overrun      = err_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus partition-advance strobes.
  always_comb begin
    state_nxt_s = state_r;
    sc_adv_s    = 1'b0;
    ga_adv_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_rise_s) state_nxt_s = ST_SC_ISSUE;
        else              state_nxt_s = ST_IDLE;
      end
      ST_SC_ISSUE: begin
        if (len_s == LEN_W'(0)) begin
          sc_adv_s    = 1'b1;
          state_nxt_s = p_last_s ? ST_GA_ISSUE : ST_SC_ISSUE;
        end else if (issue_last_s) begin
          state_nxt_s = ST_SC_DRAIN;
        end else begin
          state_nxt_s = ST_SC_ISSUE;
        end
      end
      ST_SC_DRAIN: begin
        if (ret_r == len_s) begin
          sc_adv_s    = 1'b1;
          state_nxt_s = p_last_s ? ST_GA_ISSUE : ST_SC_ISSUE;
        end else begin
          state_nxt_s = ST_SC_DRAIN;
        end
      end
      ST_GA_ISSUE: state_nxt_s = ST_GA_WAIT;
      ST_GA_WAIT: begin
        if (bus.ga_done) begin
          ga_adv_s    = 1'b1;
          state_nxt_s = p_last_s ? ST_CHECK : ST_GA_ISSUE;
        end else begin
          state_nxt_s = ST_GA_WAIT;
        end
      end
      ST_CHECK: begin
        if (cont_s) state_nxt_s = ST_SC_ISSUE;
        else        state_nxt_s = ST_FIN;
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Partition walk, burst offsets, returned-beat count, iteration and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q_r   <= 1'b0;
      p_r         <= PAR_NUM_W'(0);
      off_r       <= LEN_W'(0);
      ret_r       <= LEN_W'(0);
      iter_r      <= ITER_W'(0);
      upd_seen_r  <= 1'b0;
      converged_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      start_q_r <= start;
      if (bus.rdata_valid && !beat_ok_s) err_r <= 1'b1;
      if (start_rise_s) begin
        p_r         <= PAR_NUM_W'(0);
        off_r       <= LEN_W'(0);
        ret_r       <= LEN_W'(0);
        iter_r      <= ITER_W'(0);
        upd_seen_r  <= 1'b0;
        converged_r <= 1'b0;
      end else begin
        // p wraps to 0 after the last partition of each phase.
        if (sc_adv_s) begin
          p_r   <= p_r + PAR_NUM_W'(1'b1);
          off_r <= LEN_W'(0);
          ret_r <= LEN_W'(0);
        end else begin
          if (ga_adv_s)   p_r   <= p_r + PAR_NUM_W'(1'b1);
          if (req_fire_s) off_r <= off_r + LEN_W'(beats_s);
          if (beat_ok_s)  ret_r <= ret_r + LEN_W'(1'b1);
        end
        if (state_r == ST_CHECK) begin
          iter_r     <= iter_inc_s[ITER_W-1:0];
          upd_seen_r <= 1'b0;
          if (!cont_s) converged_r <= !updated_s;
        end else if (bus.upd_any && (state_r != ST_IDLE) && (state_r != ST_FIN)) begin
          upd_seen_r <= 1'b1;
        end
      end
    end
  end

`ifdef SSSP_SCHED_PERF_CNT_EN
  logic in_ga_s, stall_s;
  assign in_ga_s = (state_r == ST_GA_ISSUE) || (state_r == ST_GA_WAIT);
  assign stall_s = req_valid_s & ~bus.rd_req_ready;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) sat_inc = v + 32'd1;
    else                            sat_inc = v;
  endfunction

  // Saturating phase/stall cycle counters, cleared per run.
  always_ff @(posedge clk) begin
    if (!rst || start_rise_s) begin
      perf_sc_cycles    <= 32'd0;
      perf_ga_cycles    <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      perf_sc_cycles    <= sat_inc(perf_sc_cycles, in_sc_s);
      perf_ga_cycles    <= sat_inc(perf_ga_cycles, in_ga_s);
      perf_stall_cycles <= sat_inc(perf_stall_cycles, stall_s);
    end
  end
`endif

endmodule

// File: tb/tb_sssp_iter_sched.sv
// Self-checking bench for sssp_iter_sched: request/gather sequence model plus directed scenarios.
module tb_sssp_iter_sched;
  import sssp_sched_pkg::*;

  localparam int TB_MAX_ITER = 4;

  logic        clk = 1'b0;
  logic        rst, start, cfg_we;
  logic [4:0]  cfg_par;
  logic [31:0] cfg_base;
  logic [23:0] cfg_len;
  logic        busy, done, converged, err_overrun;
  logic [15:0] iter_cnt;
`ifdef SSSP_SCHED_PERF_CNT_EN
  logic [31:0] perf_sc_cycles, perf_ga_cycles, perf_stall_cycles;
`endif

  sssp_iter_sched_if bus();

  sssp_iter_sched #(.MAX_ITER(TB_MAX_ITER)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_we      (cfg_we),
    .cfg_par     (cfg_par),
    .cfg_base    (cfg_base),
    .cfg_len     (cfg_len),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .iter_cnt    (iter_cnt),
    .err_overrun (err_overrun)
`ifdef SSSP_SCHED_PERF_CNT_EN
    ,
    .perf_sc_cycles    (perf_sc_cycles),
    .perf_ga_cycles    (perf_ga_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  beats;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_base [32];
  logic [23:0] m_len  [32];
  req_t exp_req[$];
  int   exp_ga[$];
  req_t obs[$];
  bit   upd_iter [1:8];
  int   exp_iters;
  bit   exp_conv, exp_err;

  int pending = 0;
  int ga_cnt = 0;
  int drv_iter = 0;
  bit hold_beats = 0, bp_en = 0, inject_beat = 0;
  int n_done = 0, n_fire = 0, n_ga = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [3:0]  prev_beats;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Iteration count and convergence from the update schedule and the cap.
  function automatic void calc_iters();
    exp_iters = 0;
    exp_conv  = 1'b0;
    for (int i = 1; i <= TB_MAX_ITER; i++) begin
      exp_iters = i;
      if (!upd_iter[i]) begin
        exp_conv = 1'b1;
        break;
      end
    end
  endfunction

  // Every burst of every non-empty partition, then every partition gathered, per iteration.
  function automatic void build_model();
    req_t e;
    int   rem;
    exp_req.delete();
    exp_ga.delete();
    obs.delete();
    for (int it = 0; it < exp_iters; it++) begin
      for (int p = 0; p < 32; p++) begin
        for (int off = 0; off < int'(m_len[p]); off += 8) begin
          rem     = int'(m_len[p]) - off;
          e.addr  = m_base[p] + 32'(off) * 32'd8;
          e.beats = (rem > 8) ? 4'd8 : 4'(rem);
          exp_req.push_back(e);
        end
      end
      for (int p = 0; p < 32; p++) exp_ga.push_back(p);
    end
  endfunction

  // Memory and gather responders: random ready, delayed beats, delayed ga_done, scheduled upd_any.
  initial begin
    bus.rd_req_ready = 1'b0;
    bus.rdata_valid  = 1'b0;
    bus.ga_done      = 1'b0;
    bus.upd_any      = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.ga_done      = 1'b0;
      bus.upd_any      = 1'b0;
      bus.rd_req_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (inject_beat) begin
        bus.rdata_valid = 1'b1;
        inject_beat     = 0;
      end else if (pending > 0 && !hold_beats && $urandom_range(0, 3) != 0) begin
        bus.rdata_valid = 1'b1;
        pending--;
      end else begin
        bus.rdata_valid = 1'b0;
      end
      if (ga_cnt > 0) begin
        ga_cnt--;
        if (ga_cnt == 0) bus.ga_done = 1'b1;
      end
      if (bus.ga_start && rst) begin
        ga_cnt = int'($urandom_range(1, 3));
        if (bus.ga_par == 5'd0) drv_iter++;
        if (bus.ga_par == 5'd5 && drv_iter >= 1 && drv_iter <= 8 && upd_iter[drv_iter])
          bus.upd_any = 1'b1;
      end
    end
  end

  // Compare process: request stream, stability, gather order and end-of-run status.
  always @(negedge clk) begin : mon
    req_t e;
    int   g;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("req_hold_valid", 64'(bus.rd_req_valid), 64'd1);
        chk("req_hold_addr",  64'(bus.rd_req_addr),  64'(prev_addr));
        chk("req_hold_beats", 64'(bus.rd_req_beats), 64'(prev_beats));
      end
      if (!busy) chk("idle_quiet", 64'({bus.rd_req_valid, bus.ga_start}), 64'd0);
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        n_fire++;
        pending += int'(bus.rd_req_beats);
        e.addr  = bus.rd_req_addr;
        e.beats = bus.rd_req_beats;
        obs.push_back(e);
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_extra: got addr 0x%0h beats %0d, expected no request", e.addr, e.beats);
        end else begin
          e = exp_req.pop_front();
          chk("req_addr",  64'(bus.rd_req_addr),  64'(e.addr));
          chk("req_beats", 64'(bus.rd_req_beats), 64'(e.beats));
        end
      end
      if (bus.ga_start) begin
        n_ga++;
        if (exp_ga.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ga_extra: got ga_par %0d, expected no gather", bus.ga_par);
        end else begin
          g = exp_ga.pop_front();
          chk("ga_par", 64'(bus.ga_par), 64'(g));
        end
      end
      if (done) begin
        n_done++;
        chk("done_iter_cnt",    64'(iter_cnt),       64'(exp_iters));
        chk("done_converged",   64'(converged),      64'(exp_conv));
        chk("done_busy",        64'(busy),           64'd1);
        chk("done_req_left",    64'(exp_req.size()), 64'd0);
        chk("done_ga_left",     64'(exp_ga.size()),  64'd0);
        chk("done_err_overrun", 64'(err_overrun),    64'(exp_err));
      end
      prev_stall = bus.rd_req_valid && !bus.rd_req_ready;
      prev_addr  = bus.rd_req_addr;
      prev_beats = bus.rd_req_beats;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int p, input logic [31:0] base, input logic [23:0] len);
    cfg_we   = 1'b1;
    cfg_par  = 5'(p);
    cfg_base = base;
    cfg_len  = len;
    step();
    cfg_we   = 1'b0;
    m_base[p] = base;
    m_len[p]  = len;
  endtask

  task automatic run(input bit toggle);
    int d0, g0, cyc;
    bit got;
    calc_iters();
    build_model();
    drv_iter = 0;
    d0  = n_done;
    g0  = n_ga;
    got = 0;
    start = 1'b1;
    for (cyc = 0; cyc < 5000; cyc++) begin
      step();
      if (toggle && cyc == 50) start = 1'b0;
      if (toggle && cyc == 60) start = 1'b1;
      if (n_done != d0) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got no done within 5000 cycles, expected done");
    end
    step();
    chk("post_busy", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (10) step();
    chk("done_once", 64'(n_done - d0), 64'd1);
    chk("ga_count",  64'(n_ga - g0),   64'(32 * exp_iters));
  endtask

  initial begin
    int f0;
    bit got;
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0;
    cfg_par = 5'd0; cfg_base = 32'd0; cfg_len = 24'd0;
    exp_err = 1'b0;
    for (int i = 0; i < 32; i++) begin m_base[i] = 32'd0; m_len[i] = 24'd0; end
    for (int i = 1; i <= 8; i++) upd_iter[i] = 0;
    repeat (3) step();
    chk("reset_outputs", 64'({bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_beats, bus.ga_start,
                              bus.ga_par, busy, done, converged, iter_cnt, err_overrun}), 64'd0);
    rst = 1'b1;
    step();

    // Single partition, no updates.
    cfg_write(0, 32'h0000_1000, 24'd20);
    run(0);
    chk("t1_req0", 64'(obs[0]), 64'({32'h0000_1000, 4'd8}));
    chk("t1_req1", 64'(obs[1]), 64'({32'h0000_1040, 4'd8}));
    chk("t1_req2", 64'(obs[2]), 64'({32'h0000_1080, 4'd4}));
    chk("t1_nreq", 64'(obs.size()), 64'd3);
    chk("t1_iter", 64'(iter_cnt), 64'd1);
    chk("t1_conv", 64'(converged), 64'd1);

    // Updates in iterations 1 and 2, with backpressure.
    bp_en = 1;
    upd_iter[1] = 1; upd_iter[2] = 1;
    calc_iters();
    chk("t2_model_iters", 64'(exp_iters), 64'd3);
    run(0);
    chk("t2_iter", 64'(iter_cnt), 64'd3);
    chk("t2_conv", 64'(converged), 64'd1);

    // Updates every iteration hit the cap; start toggled while busy.
    for (int i = 1; i <= 8; i++) upd_iter[i] = 1;
    calc_iters();
    chk("t3_model_iters", 64'(exp_iters), 64'd4);
    run(1);
    chk("t3_iter", 64'(iter_cnt), 64'd4);
    chk("t3_conv", 64'(converged), 64'd0);

    // Several partitions, one wrapping the address space, one burst remainder of 1.
    for (int i = 1; i <= 8; i++) upd_iter[i] = 0;
    cfg_write(3,  32'hFFFF_FFF0, 24'd9);
    cfg_write(10, 32'h0000_2000, 24'd17);
    cfg_write(31, 32'h0000_0020, 24'd1);
    run(0);
    chk("t4_wrap_req0", 64'(obs[3]), 64'({32'hFFFF_FFF0, 4'd8}));
    chk("t4_wrap_req1", 64'(obs[4]), 64'({32'h0000_0030, 4'd1}));
    chk("t4_last_req",  64'(obs[8]), 64'({32'h0000_0020, 4'd1}));

    // Stray beat while idle is a sticky overrun.
    @(negedge clk); inject_beat = 1;
    repeat (3) step();
    chk("overrun_set", 64'(err_overrun), 64'd1);
    exp_err = 1'b1;
    run(0);
    chk("overrun_sticky", 64'(err_overrun), 64'd1);

    // Reset while draining partition 0, then a run over the cleared table.
    hold_beats = 1;
    calc_iters();
    build_model();
    f0 = n_fire;
    got = 0;
    start = 1'b1;
    for (int c = 0; c < 500; c++) begin
      step();
      if (n_fire - f0 >= 3) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d requests, expected 3", n_fire - f0);
    end
    chk("drain_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("midrun_reset_outputs", 64'({bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_beats, bus.ga_start,
                                     bus.ga_par, busy, done, converged, iter_cnt, err_overrun}), 64'd0);
    @(negedge clk);
    pending = 0;
    hold_beats = 0;
    for (int i = 0; i < 32; i++) begin m_base[i] = 32'd0; m_len[i] = 24'd0; end
    exp_err = 1'b0;
    step();
    rst = 1'b1;
    step();
    run(0);
    chk("t6_nreq", 64'(obs.size()), 64'd0);
    chk("t6_iter", 64'(iter_cnt), 64'd1);
    chk("t6_conv", 64'(converged), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
